instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_queue_store.sv | 58 +++++
 rtl/instr_fetch_queue.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, fetch queue entry layout and fetch FSM encoding
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    // FETCH: normal prefetching. DISCARD: a read issued before a redirect is
    // still outstanding and its data must be thrown away when it returns.
    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_store.sv
// rtl/fetch_queue_store.sv - DEPTH x {instr, pc} circular buffer for the fetch queue
//
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   flush         - empties the buffer (pointers and count to zero)
//   push, wdata   - append one entry; caller guarantees the buffer is not full
//   pop           - drop the head entry; caller guarantees the buffer is not empty
//   rdata         - head entry (meaningful only while count != 0)
//   count         - number of stored entries, 0..DEPTH
module fetch_queue_store
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     wdata,
    input  logic             pop,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset: it is only observed while count != 0.
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction prefetch queue with redirect/flush and stale-read discard
//
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   mem_req, mem_addr   - instruction memory read request and word address (registered)
//   mem_ack, mem_rdata  - read completion and returned word (may arrive in the request cycle)
//   instr, instr_valid  - head-of-queue instruction and its valid flag
//   pc_out              - word address of the head instruction
//   IRWrite             - consumer takes the head instruction this edge
//   redirect            - taken branch/jump: flush the queue, refetch from redirect_pc
//   redirect_pc         - new fetch address
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clock,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               IRWrite,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int               CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    fetch_state_t      state;
    fetch_state_t      state_n;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_n;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic              mem_req_q;
    logic              mem_req_n;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] mem_addr_n;

    logic              ack_ok;
    logic              push;
    logic              pop;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head;

    // An ack only counts against a request we are actually presenting; this
    // also filters acks for requests that were issued before a reset.
    assign ack_ok   = mem_ack && mem_req_q;
    assign push     = (state == FETCH) && ack_ok && !redirect;
    assign pop      = IRWrite && (count != '0) && !redirect;
    assign wr_entry = '{instr: mem_rdata, pc: fetch_pc};

    fetch_queue_store #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_store (
        .clock (clock),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            FETCH: begin
                // A read already in flight cannot be withdrawn, so wait it out.
                if (redirect && mem_req_q && !mem_ack) begin
                    state_n = DISCARD;
                end
            end
            DISCARD: begin
                if (ack_ok) begin
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    // Next values for the fetch pointer, occupancy and registered request outputs
    always_comb begin
        fetch_pc_n = fetch_pc;
        if (redirect) begin
            fetch_pc_n = redirect_pc;
        end else if (push) begin
            fetch_pc_n = fetch_pc + 16'd1;
        end

        count_n = redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);

        // In DISCARD the stale request must stay on the bus unchanged.
        if (state_n == DISCARD) begin
            mem_req_n  = 1'b1;
            mem_addr_n = mem_addr_q;
        end else begin
            mem_req_n  = (count_n < FULL_COUNT);
            mem_addr_n = fetch_pc_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            fetch_pc   <= fetch_pc_n;
            mem_req_q  <= mem_req_n;
            mem_addr_q <= mem_addr_n;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.instr : '0;
    assign pc_out      = instr_valid ? head.pc : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard testbench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        IRWrite;
    logic [15:0] pc_out;
    logic        redirect;
    logic [15:0] redirect_pc;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] sb [$];
    logic [15:0] exp_fetch;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .IRWrite     (IRWrite),
        .pc_out      (pc_out),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1A2B;
        return {a[7:0], ~a[15:8]};
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    // One cycle of normal fetch traffic; scoreboard pushes on accepted acks
    // and pops/compares on accepted IRWrite.
    task automatic drive_cycle(input bit ack, input bit irw);
        logic [31:0] exp;
        if (irw && instr_valid) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL pop_unexpected: instr_valid=1 pc_out=%h, expected empty queue", pc_out);
            end else begin
                exp = sb.pop_front();
                if ({instr, pc_out} !== exp) begin
                    mismatched++;
                    $display("FAIL pop_head: got instr=%h pc=%h, expected instr=%h pc=%h",
                             instr, pc_out, exp[31:16], exp[15:0]);
                end
            end
        end
        if (mem_req) begin
            compared++;
            if (mem_addr !== exp_fetch) begin
                mismatched++;
                $display("FAIL fetch_addr: got %h, expected %h", mem_addr, exp_fetch);
            end
        end
        if (ack && mem_req) begin
            sb.push_back({mem_word(mem_addr), mem_addr});
            exp_fetch = exp_fetch + 16'd1;
        end
        mem_ack   = ack;
        mem_rdata = ack ? mem_word(mem_addr) : 16'hDEAD;
        IRWrite   = irw;
        redirect  = 1'b0;
        tick();
        compared++;
        if (instr_valid !== (sb.size() != 0)) begin
            mismatched++;
            $display("FAIL valid_track: got %b, expected %b", instr_valid, sb.size() != 0);
        end
        compared++;
        if (mem_req !== (sb.size() < DEPTH)) begin
            mismatched++;
            $display("FAIL req_track: got %b, expected %b", mem_req, sb.size() < DEPTH);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ack = 1'b0; IRWrite = 1'b0; redirect = 1'b0;
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        compared++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: mem_req=%b instr_valid=%b, expected 0 0", mem_req, instr_valid);
        end
        compared++;
        if (instr !== 16'h0000 || pc_out !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_data: instr=%h pc_out=%h, expected 0000 0000", instr, pc_out);
        end
        // ack held high across release must be ignored (no request presented yet)
        reset = 1'b0;
        tick();
        compared++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC || instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: mem_req=%b mem_addr=%h instr_valid=%b, expected 1 %h 0",
                     mem_req, mem_addr, instr_valid, RESET_PC);
        end
        sb.delete();
        exp_fetch = RESET_PC;
    endtask

    task automatic test_first_fetch();
        drive_cycle(1'b1, 1'b0);
        compared++;
        if (instr !== 16'h1A2B || pc_out !== 16'h0000 || instr_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL first_fetch: instr=%h pc=%h valid=%b, expected 1a2b 0000 1",
                     instr, pc_out, instr_valid);
        end
    endtask

    task automatic test_fill();
        drive_cycle(1'b1, 1'b0);
        compared++;
        if (mem_req !== 1'b0) begin
            mismatched++;
            $display("FAIL fill_req: mem_req=%b, expected 0", mem_req);
        end
        drive_cycle(1'b1, 1'b0);
        compared++;
        if (pc_out !== 16'h0000 || sb.size() != DEPTH) begin
            mismatched++;
            $display("FAIL fill_hold: pc_out=%h sb=%0d, expected 0000 %0d", pc_out, sb.size(), DEPTH);
        end
    endtask

    task automatic test_pop_one();
        drive_cycle(1'b0, 1'b1);
        compared++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0002 || pc_out !== 16'h0001) begin
            mismatched++;
            $display("FAIL pop_one: mem_req=%b mem_addr=%h pc_out=%h, expected 1 0002 0001",
                     mem_req, mem_addr, pc_out);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1);
        for (int i = 0; i < 150; i++) drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1'b0, 1'b1);
    endtask

    task automatic test_discard();
        // redirect with a same-cycle ack: the ack data is dropped, no DISCARD
        mem_ack = 1'b1; mem_rdata = mem_word(mem_addr); IRWrite = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0005;
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        sb.delete();
        exp_fetch = 16'h0005;
        compared++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0005 || instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL redirect_ack: mem_req=%b mem_addr=%h valid=%b, expected 1 0005 0",
                     mem_req, mem_addr, instr_valid);
        end
        // redirect with the addr-5 read outstanding
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        exp_fetch = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (mem_req !== 1'b1 || mem_addr !== 16'h0005 || instr_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL discard_hold%0d: mem_req=%b mem_addr=%h valid=%b, expected 1 0005 0",
                         i, mem_req, mem_addr, instr_valid);
            end
            if (i < 2) tick();
        end
        mem_ack = 1'b1; mem_rdata = mem_word(16'h0005);
        tick();
        mem_ack = 1'b0;
        compared++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL discard_drop: mem_req=%b mem_addr=%h valid=%b, expected 1 0040 0",
                     mem_req, mem_addr, instr_valid);
        end
        drive_cycle(1'b1, 1'b0);
        compared++;
        if (instr !== mem_word(16'h0040) || pc_out !== 16'h0040) begin
            mismatched++;
            $display("FAIL discard_refetch: instr=%h pc=%h, expected %h 0040",
                     instr, pc_out, mem_word(16'h0040));
        end
    endtask

    task automatic test_wrap();
        mem_ack = 1'b1; mem_rdata = mem_word(mem_addr); IRWrite = 1'b0;
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        sb.delete();
        exp_fetch = 16'hFFFF;
        compared++;
        if (mem_addr !== 16'hFFFF || instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL wrap_start: mem_addr=%h valid=%b, expected ffff 0", mem_addr, instr_valid);
        end
        drive_cycle(1'b1, 1'b0);
        compared++;
        if (mem_addr !== 16'h0000) begin
            mismatched++;
            $display("FAIL wrap_addr: mem_addr=%h, expected 0000", mem_addr);
        end
        drive_cycle(1'b1, 1'b0);
        compared++;
        if (pc_out !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL wrap_head: pc_out=%h, expected ffff", pc_out);
        end
        drive_cycle(1'b0, 1'b1);
        compared++;
        if (pc_out !== 16'h0000 || instr !== 16'h1A2B) begin
            mismatched++;
            $display("FAIL wrap_next: pc_out=%h instr=%h, expected 0000 1a2b", pc_out, instr);
        end
        drive_cycle(1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4 && sb.size() < DEPTH; i++) drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1);
        // queue holds data and a request is pending; reset with IRWrite high
        reset = 1'b1; mem_ack = 1'b0; IRWrite = 1'b1;
        tick();
        compared++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0000 || pc_out !== 16'h0000) begin
            mismatched++;
            $display("FAIL midreset: mem_req=%b valid=%b instr=%h pc=%h, expected 0 0 0000 0000",
                     mem_req, instr_valid, instr, pc_out);
        end
        mem_ack = 1'b1; mem_rdata = 16'hBAD0; IRWrite = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        mem_ack = 1'b0;
        compared++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC || instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_release: mem_req=%b mem_addr=%h valid=%b, expected 1 %h 0",
                     mem_req, mem_addr, instr_valid, RESET_PC);
        end
        sb.delete();
        exp_fetch = RESET_PC;
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000;
        IRWrite = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        exp_fetch = RESET_PC;
        test_reset();
        test_first_fetch();
        test_fill();
        test_pop_one();
        test_back_to_back();
        test_discard();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
